// File: rtl/memcpy_pkg.sv
// Shared definitions for the memcpy burst splitter: one-hot state codes, width helpers
// and the registered burst descriptor layout.
package memcpy_pkg;

   localparam int ST_W = 5;
   localparam logic [ST_W-1:0] ST_IDLE  = 5'b00001;
   localparam logic [ST_W-1:0] ST_INIT  = 5'b00010;
   localparam logic [ST_W-1:0] ST_CALC  = 5'b00100;
   localparam logic [ST_W-1:0] ST_ISSUE = 5'b01000;
   localparam logic [ST_W-1:0] ST_DRAIN = 5'b10000;

   // Descriptor fields sized for the widest address and a 64-beat maximum burst.
   localparam int DESC_ADDR_W = 64;
   localparam int DESC_LEN_W  = 7;

   typedef struct packed {
      logic [DESC_ADDR_W-1:0] addr;
      logic [DESC_LEN_W-1:0]  len;
   } burst_desc_t;

   function automatic int beat_shift(input int beat_bytes);
      return $clog2(beat_bytes);
   endfunction

   function automatic int bound_shift(input int boundary);
      return $clog2(boundary);
   endfunction

   function automatic int len_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/memcpy_burst_len_calc.sv
// Beat count of the next burst: min(MAX_BURST, beats to next BOUNDARY, beats left).
// Purely combinational; no handshake.
module memcpy_burst_len_calc
   import memcpy_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int BEAT_BYTES = 64,
   parameter int MAX_BURST  = 64,
   parameter int BOUNDARY   = 4096,
   parameter int LEN_W      = len_w(MAX_BURST)
) (
   input  logic [ADDR_W-1:0] cur,
   input  logic [ADDR_W-1:0] end_al,
   output logic [LEN_W-1:0]  len
);

   localparam int BEAT_SHIFT  = beat_shift(BEAT_BYTES);
   localparam int BOUND_SHIFT = bound_shift(BOUNDARY);
   localparam logic [ADDR_W-1:0] BOUND_BYTES = ADDR_W'(1) << BOUND_SHIFT;

   logic [ADDR_W-1:0] bound_off;
   logic [ADDR_W-1:0] to_bound;
   logic [ADDR_W-1:0] to_end;
   logic [ADDR_W-1:0] beats;

   always_comb begin
      bound_off = cur & (BOUND_BYTES - ADDR_W'(1));
      to_bound  = (BOUND_BYTES - bound_off) >> BEAT_SHIFT;
      to_end    = (end_al - cur) >> BEAT_SHIFT;
      beats     = ADDR_W'(MAX_BURST);
      if (to_bound < beats) beats = to_bound;
      if (to_end < beats)   beats = to_end;
      len = LEN_W'(beats);
   end

endmodule

// File: rtl/memcpy_burst_splitter.sv
// Splits one copy request into beat-aligned, boundary-safe bursts; one CALC cycle per burst,
// descriptor held until burst_ready, stalls at MAX_OUT in flight. Optional MEMCPY_BYTE_MASK_EN.
module memcpy_burst_splitter
   import memcpy_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int BEAT_BYTES = 64,
   parameter int MAX_BURST  = 64,
   parameter int BOUNDARY   = 4096,
   parameter int MAX_OUT    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           memcpy_start,
   input  logic [ADDR_W-1:0]              memcpy_addr,
   input  logic [ADDR_W-1:0]              memcpy_len,
   input  logic                           memcpy_abort,
   output logic                           burst_valid,
   input  logic                           burst_ready,
   output logic [ADDR_W-1:0]              burst_addr,
   output logic [$clog2(MAX_BURST+1)-1:0] burst_len,
   input  logic                           burst_done,
   output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
   output logic                           memcpy_done,
   output logic                           err_unexp_done
`ifdef MEMCPY_BYTE_MASK_EN
   ,
   output logic [BEAT_BYTES-1:0]          burst_first_be,
   output logic [BEAT_BYTES-1:0]          burst_last_be
`endif
);

   localparam int LEN_W      = len_w(MAX_BURST);
   localparam int OUT_W      = $clog2(MAX_OUT + 1);
   localparam int BEAT_SHIFT = beat_shift(BEAT_BYTES);
   localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(BEAT_BYTES - 1);

   logic [ST_W-1:0]   state_q, state_d;
   logic [ADDR_W-1:0] req_addr_q, req_len_q;
   logic [ADDR_W-1:0] cur_q, end_al_q;
   logic [ADDR_W-1:0] end_w;
   burst_desc_t       desc_q;
   logic              abort_q;
   logic [LEN_W-1:0]  calc_len;

   logic              hs, out_full, abort_pend, calc_go, done_unexp, finish;
   logic [OUT_W-1:0]  cnt_d;
   logic [ADDR_W-1:0] cur_adv;

   assign end_w      = req_addr_q + req_len_q;
   assign burst_addr = desc_q.addr[ADDR_W-1:0];
   assign burst_len  = desc_q.len[LEN_W-1:0];

   memcpy_burst_len_calc #(
      .ADDR_W     (ADDR_W),
      .BEAT_BYTES (BEAT_BYTES),
      .MAX_BURST  (MAX_BURST),
      .BOUNDARY   (BOUNDARY),
      .LEN_W      (LEN_W)
   ) u_len_calc (
      .cur    (cur_q),
      .end_al (end_al_q),
      .len    (calc_len)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (memcpy_start) state_d = ST_INIT;
         ST_INIT:  state_d = (req_len_q == '0) ? ST_IDLE : ST_CALC;
         ST_CALC: begin
            if (abort_pend)   state_d = ST_DRAIN;
            else if (calc_go) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (hs) state_d = (cur_adv >= end_al_q || abort_pend) ? ST_DRAIN : ST_CALC;
         end
         ST_DRAIN: if (cnt_d == '0) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hs         = burst_valid && burst_ready;
      out_full   = (outstanding == OUT_W'(MAX_OUT));
      abort_pend = abort_q || memcpy_abort;
      // A same-cycle completion frees a slot, so a full window does not stall.
      calc_go    = (state_q == ST_CALC) && !abort_pend && !(out_full && !burst_done);
      cur_adv    = cur_q + (ADDR_W'(desc_q.len) << BEAT_SHIFT);
      done_unexp = burst_done && (outstanding == '0) && !hs;
      cnt_d      = outstanding;
      if (hs && !burst_done)                           cnt_d = outstanding + OUT_W'(1);
      else if (!hs && burst_done && outstanding != '0) cnt_d = outstanding - OUT_W'(1);
      finish     = ((state_q == ST_DRAIN) && (cnt_d == '0)) ||
                   ((state_q == ST_INIT) && (req_len_q == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr_q     <= '0;
         req_len_q      <= '0;
         cur_q          <= '0;
         end_al_q       <= '0;
         desc_q         <= '0;
         abort_q        <= 1'b0;
         burst_valid    <= 1'b0;
         outstanding    <= '0;
         memcpy_done    <= 1'b1;
         err_unexp_done <= 1'b0;
      end else begin
         outstanding <= cnt_d;
         if (done_unexp) err_unexp_done <= 1'b1;
         if (state_q == ST_IDLE)  abort_q <= 1'b0;
         else if (memcpy_abort)   abort_q <= 1'b1;
         if (state_q == ST_IDLE && memcpy_start) begin
            req_addr_q  <= memcpy_addr;
            req_len_q   <= memcpy_len;
            memcpy_done <= 1'b0;
         end
         if (state_q == ST_INIT) begin
            cur_q    <= req_addr_q & ~BEAT_MASK;
            end_al_q <= (end_w + BEAT_MASK) & ~BEAT_MASK;
         end
         if (calc_go) begin
            desc_q.addr <= DESC_ADDR_W'(cur_q);
            desc_q.len  <= DESC_LEN_W'(calc_len);
            burst_valid <= 1'b1;
         end
         if (hs) begin
            burst_valid <= 1'b0;
            cur_q       <= cur_adv;
         end
         if (finish) memcpy_done <= 1'b1;
      end
   end

`ifdef MEMCPY_BYTE_MASK_EN
   localparam logic [BEAT_BYTES-1:0] BE_ONES = '1;

   logic              first_q;
   logic [ADDR_W-1:0] end_q;
   logic [ADDR_W-1:0] end_off;
   logic              calc_last;

   assign end_off   = end_q & BEAT_MASK;
   assign calc_last = (cur_q + (ADDR_W'(calc_len) << BEAT_SHIFT)) >= end_al_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q        <= 1'b0;
         end_q          <= '0;
         burst_first_be <= '0;
         burst_last_be  <= '0;
      end else begin
         if (state_q == ST_INIT) begin
            first_q <= 1'b1;
            end_q   <= end_w;
         end
         if (hs) first_q <= 1'b0;
         if (calc_go) begin
            burst_first_be <= first_q ? (BE_ONES << (req_addr_q & BEAT_MASK)) : BE_ONES;
            burst_last_be  <= (calc_last && end_off != '0) ?
                              (BE_ONES >> (ADDR_W'(BEAT_BYTES) - end_off)) : BE_ONES;
         end
      end
   end
`endif

endmodule

// File: tb/tb_memcpy_burst_splitter.sv
// Scoreboard bench for memcpy_burst_splitter at default parameters; an engine model
// drives burst_ready/burst_done and a monitor pops expected descriptors on each handshake.
module tb_memcpy_burst_splitter;

   typedef struct {
      logic [63:0] addr;
      logic [6:0]  len;
      logic [63:0] fbe;
      logic [63:0] lbe;
   } exp_t;

   logic        clk, rst;
   logic        memcpy_start, memcpy_abort;
   logic [63:0] memcpy_addr, memcpy_len;
   logic        burst_valid, burst_ready, burst_done;
   logic [63:0] burst_addr;
   logic [6:0]  burst_len;
   logic [2:0]  outstanding;
   logic        memcpy_done, err_unexp_done;
`ifdef MEMCPY_BYTE_MASK_EN
   logic [63:0] burst_first_be, burst_last_be;
`endif

   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];

   // monitor-owned
   int   hs_count = 0;
   int   exp_out = 0;
   logic hs_prev = 0, done_prev = 0;
   // engine-owned
   int   done_count = 0;
   int   inject_ack = 0;
   // main-owned knobs
   logic ready_on = 1, ready_rand = 0, done_en = 1, done_rand = 0;
   int   inject_req = 0;

   memcpy_burst_splitter dut (
      .clk            (clk),
      .rst            (rst),
      .memcpy_start   (memcpy_start),
      .memcpy_addr    (memcpy_addr),
      .memcpy_len     (memcpy_len),
      .memcpy_abort   (memcpy_abort),
      .burst_valid    (burst_valid),
      .burst_ready    (burst_ready),
      .burst_addr     (burst_addr),
      .burst_len      (burst_len),
      .burst_done     (burst_done),
      .outstanding    (outstanding),
      .memcpy_done    (memcpy_done),
      .err_unexp_done (err_unexp_done)
`ifdef MEMCPY_BYTE_MASK_EN
      ,
      .burst_first_be (burst_first_be),
      .burst_last_be  (burst_last_be)
`endif
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] a, input logic [6:0] l);
      exp_t e;
      e.addr = a; e.len = l; e.fbe = '1; e.lbe = '1;
      sbq.push_back(e);
   endtask

   // Reference split for BEAT_BYTES=64, MAX_BURST=64, BOUNDARY=4096.
   task automatic push_model(input logic [63:0] a, input logic [63:0] l);
      logic [63:0] cur, endv, endal, bb, rem, n, ones;
      bit first;
      exp_t e;
      ones = '1;
      cur = a & ~64'd63;
      endv = a + l;
      endal = (endv + 64'd63) & ~64'd63;
      first = 1;
      while (cur < endal) begin
         bb = (64'd4096 - (cur & 64'd4095)) >> 6;
         rem = (endal - cur) >> 6;
         n = 64;
         if (bb < n) n = bb;
         if (rem < n) n = rem;
         e.addr = cur;
         e.len = n[6:0];
         e.fbe = first ? (ones << a[5:0]) : ones;
         e.lbe = ((cur + n * 64) >= endal && endv[5:0] != 0) ? (ones >> (64 - endv[5:0])) : ones;
         sbq.push_back(e);
         cur = cur + n * 64;
         first = 0;
      end
   endtask

   // Engine: ready pattern and one done per accepted burst.
   initial begin
      burst_ready = 0;
      burst_done = 0;
      forever begin
         @(posedge clk);
         #1;
         burst_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_on;
         burst_done = 0;
         if (inject_req != inject_ack) begin
            burst_done = 1;
            inject_ack++;
         end else if (done_en && (hs_count - done_count) > 0 &&
                      (!done_rand || $urandom_range(0, 2) != 0)) begin
            burst_done = 1;
            done_count++;
         end
      end
   end

   // Monitor: outstanding model and scoreboard pop on handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_out = 0;
            hs_prev = 0;
            done_prev = 0;
         end else begin
            if (hs_prev && !done_prev) exp_out++;
            else if (!hs_prev && done_prev && exp_out > 0) exp_out--;
            check("outstanding", 64'(outstanding), 64'(exp_out));
            hs_prev = burst_valid && burst_ready;
            done_prev = burst_done;
            if (hs_prev) begin
               hs_count++;
               if (sbq.size() == 0) begin
                  check("unexp_burst", 64'(1), 64'(0));
               end else begin
                  e = sbq.pop_front();
                  check("burst_addr", burst_addr, e.addr);
                  check("burst_len", 64'(burst_len), 64'(e.len));
`ifdef MEMCPY_BYTE_MASK_EN
                  check("first_be", burst_first_be, e.fbe);
                  check("last_be", burst_last_be, e.lbe);
`endif
               end
            end
         end
      end
   end

   task automatic start_copy(input logic [63:0] a, input logic [63:0] l);
      @(posedge clk); #1;
      memcpy_addr = a;
      memcpy_len = l;
      memcpy_start = 1;
      @(posedge clk); #1;
      memcpy_start = 0;
      @(negedge clk); #1;
      check("done_clr", 64'(memcpy_done), 64'(0));
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (memcpy_done) break;
         @(negedge clk); #1;
      end
      check(tag, 64'(memcpy_done), 64'(1));
      check("all_done_rcvd", 64'(hs_count - done_count), 64'(0));
      check("sb_empty", 64'(sbq.size()), 64'(0));
   endtask

   initial begin
      int h0;
      rst = 1;
      memcpy_start = 0;
      memcpy_abort = 0;
      memcpy_addr = 0;
      memcpy_len = 0;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(burst_valid), 64'(0));
      check("rst_addr", burst_addr, 64'(0));
      check("rst_len", 64'(burst_len), 64'(0));
      check("rst_out", 64'(outstanding), 64'(0));
      check("rst_done", 64'(memcpy_done), 64'(1));
      check("rst_err", 64'(err_unexp_done), 64'(0));
      @(posedge clk); #1;
      rst = 0;

      // Three full 4 KB bursts.
      push_exp(64'h0, 7'd64); push_exp(64'h1000, 7'd64); push_exp(64'h2000, 7'd64);
      start_copy(64'h0, 64'h3000);
      wait_done("basic_done", 500);

      // Two single beats either side of a 4 KB boundary.
      push_exp(64'h1FC0, 7'd1); push_exp(64'h2000, 7'd1);
      start_copy(64'h1FC0, 64'h80);
      wait_done("bound_done", 500);

      // Unaligned patterns with random ready/done timing.
      ready_rand = 1; done_rand = 1;
      push_model(64'h0FF0, 64'h2345);
      start_copy(64'h0FF0, 64'h2345);
      wait_done("rand1_done", 3000);
      push_model(64'h123, 64'h1);
      start_copy(64'h123, 64'h1);
      wait_done("rand2_done", 500);
      push_model(64'hFFC, 64'h10);
      start_copy(64'hFFC, 64'h10);
      wait_done("rand3_done", 500);
      ready_rand = 0; done_rand = 0;

      // Outstanding window fills and stalls, then streams with overlapping done.
      done_en = 0;
      h0 = hs_count;
      push_model(64'h0, 64'h10000);
      start_copy(64'h0, 64'h10000);
      repeat (40) @(negedge clk);
      #1;
      check("stall_hs", 64'(hs_count - h0), 64'(4));
      check("stall_out", 64'(outstanding), 64'(4));
      check("stall_valid", 64'(burst_valid), 64'(0));
      done_en = 1;
      wait_done("stall_done", 3000);
      check("stall_total", 64'(hs_count - h0), 64'(16));

      // Abort after the second handshake.
      done_en = 0;
      h0 = hs_count;
      push_exp(64'h0, 7'd64); push_exp(64'h1000, 7'd64);
      start_copy(64'h0, 64'h4000);
      for (int i = 0; i < 100 && (hs_count - h0) < 2; i++) begin
         @(negedge clk); #1;
      end
      check("abort_2hs", 64'(hs_count - h0), 64'(2));
      @(posedge clk); #1;
      memcpy_abort = 1;
      @(posedge clk); #1;
      memcpy_abort = 0;
      repeat (5) @(negedge clk);
      #1;
      check("abort_no_vld", 64'(burst_valid), 64'(0));
      check("abort_hold", 64'(memcpy_done), 64'(0));
      done_en = 1;
      wait_done("abort_done", 200);
      check("abort_total", 64'(hs_count - h0), 64'(2));

      // Abort while a descriptor is presented: it must still be accepted.
      ready_on = 0;
      h0 = hs_count;
      push_exp(64'h0, 7'd64);
      start_copy(64'h0, 64'h4000);
      for (int i = 0; i < 50 && !burst_valid; i++) begin
         @(negedge clk); #1;
      end
      memcpy_abort = 1;
      @(posedge clk); #1;
      memcpy_abort = 0;
      @(negedge clk); #1;
      check("issue_abort_vld", 64'(burst_valid), 64'(1));
      ready_on = 1;
      wait_done("issue_abort_done", 200);
      check("issue_abort_total", 64'(hs_count - h0), 64'(1));

      // Zero length: no burst, done low for exactly one cycle.
      h0 = hs_count;
      start_copy(64'h40, 64'h0);
      @(negedge clk); #1;
      check("len0_done", 64'(memcpy_done), 64'(1));
      repeat (3) @(negedge clk);
      #1;
      check("len0_nohs", 64'(hs_count - h0), 64'(0));
      check("err_pre", 64'(err_unexp_done), 64'(0));
      inject_req++;
      repeat (3) @(negedge clk);
      #1;
      check("err_unexp", 64'(err_unexp_done), 64'(1));

      // Reset mid-ISSUE drops valid immediately.
      ready_on = 0;
      start_copy(64'h0, 64'h3000);
      for (int i = 0; i < 50 && !burst_valid; i++) begin
         @(negedge clk); #1;
      end
      check("pre_rst_vld", 64'(burst_valid), 64'(1));
      rst = 1;
      #1;
      check("arst_valid", 64'(burst_valid), 64'(0));
      check("arst_done", 64'(memcpy_done), 64'(1));
      check("arst_addr", burst_addr, 64'(0));
      check("arst_err", 64'(err_unexp_done), 64'(0));
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst = 0;
      ready_on = 1;
      repeat (3) @(negedge clk);
      #1;
      check("post_rst_out", 64'(outstanding), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
